// File: rtl/bfloat16_add_sequencer.sv
// Feeds operand pairs from an input FIFO into a fixed 3-cycle bfloat16 adder and
// collects sums into a credit-limited result FIFO, tracking the adder's round phase.
module bfloat16_add_sequencer #(
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 2
) (
    input  logic        clock,
    input  logic        nreset,
    input  logic        in_valid,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        in_ready,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    input  logic [15:0] add_sum,
    input  logic        add_ready,
    output logic        out_valid,
    output logic [15:0] out_sum,
    input  logic        out_ready,
    output logic        busy,
    output logic        sync_err
);
    localparam int IAW = $clog2(IN_DEPTH);
    localparam int OAW = $clog2(OUT_DEPTH);
    localparam logic [IAW:0] IN_FULL  = (IAW+1)'(IN_DEPTH);
    localparam logic [OAW:0] OUT_FULL = (OAW+1)'(OUT_DEPTH);

    typedef enum logic {SYNC, RUN} state_t;

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_phase;
    logic            r_inflight;
    logic            r_sync_err;
    logic [15:0]     r_add_a, r_add_b;

    logic [31:0]     r_imem [IN_DEPTH];
    logic [IAW-1:0]  r_iwr, r_ird;
    logic [IAW:0]    r_icnt;

    logic [15:0]     r_omem [OUT_DEPTH];
    logic [OAW-1:0]  r_owr, r_ord;
    logic [OAW:0]    r_ocnt;

    logic            w_in_push, w_err, w_bound, w_cap, w_out_pop, w_issue;
    logic [OAW:0]    w_ocnt_after;

    assign w_in_push    = in_valid & in_ready;
    // In RUN the adder must pulse ready exactly when the phase reaches 2.
    assign w_err        = (r_state == RUN) &&
                          ((add_ready && (r_phase != 2'd2)) || ((r_phase == 2'd2) && !add_ready));
    assign w_bound      = add_ready && !w_err;
    assign w_cap        = w_bound && r_inflight;
    assign w_out_pop    = out_valid && out_ready;
    assign w_ocnt_after = r_ocnt + (OAW+1)'(w_cap) - (OAW+1)'(w_out_pop);
    // A job is only issued if its result is guaranteed a slot when it returns.
    assign w_issue      = w_bound && (r_icnt != '0) && (w_ocnt_after < OUT_FULL);

    assign in_ready  = (r_icnt != IN_FULL);
    assign out_valid = (r_ocnt != '0);
    assign out_sum   = out_valid ? r_omem[r_ord] : 16'h0000;
    assign busy      = r_inflight || (r_icnt != '0) || out_valid;
    assign sync_err  = r_sync_err;
    assign add_a     = r_add_a;
    assign add_b     = r_add_b;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) r_state <= SYNC;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SYNC: if (add_ready) w_state_nxt = RUN;
            RUN:  if (w_err)     w_state_nxt = SYNC;
            default:             w_state_nxt = SYNC;
        endcase
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_phase    <= 2'd0;
            r_inflight <= 1'b0;
            r_sync_err <= 1'b0;
            r_add_a    <= 16'h0000;
            r_add_b    <= 16'h0000;
        end else begin
            if (add_ready || (r_phase == 2'd2)) r_phase <= 2'd0;
            else                                r_phase <= r_phase + 2'd1;
            if (w_err) begin
                r_sync_err <= 1'b1;
                r_inflight <= 1'b0;
            end else if (w_bound) begin
                r_inflight <= w_issue;
            end
            if (w_issue) begin
                r_add_a <= r_imem[r_ird][31:16];
                r_add_b <= r_imem[r_ird][15:0];
            end
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_iwr  <= '0;
            r_ird  <= '0;
            r_icnt <= '0;
            r_owr  <= '0;
            r_ord  <= '0;
            r_ocnt <= '0;
        end else begin
            if (w_in_push) r_iwr <= r_iwr + 1'b1;
            if (w_issue)   r_ird <= r_ird + 1'b1;
            r_icnt <= r_icnt + (IAW+1)'(w_in_push) - (IAW+1)'(w_issue);
            if (w_cap)     r_owr <= r_owr + 1'b1;
            if (w_out_pop) r_ord <= r_ord + 1'b1;
            r_ocnt <= w_ocnt_after;
        end
    end

    // Storage needs no reset; occupancy counters gate every read.
    always_ff @(posedge clock) begin
        if (w_in_push) r_imem[r_iwr] <= {in_a, in_b};
        if (w_cap)     r_omem[r_owr] <= add_sum;
    end
endmodule

// File: tb/tb_bfloat16_add_sequencer.sv
// Directed bench: a 3-cycle model adder drives the sequencer; results are
// collected with cycle stamps and checked against hand-computed bfloat16 sums.
module tb_bfloat16_add_sequencer;
    logic        clock = 1'b0;
    logic        nreset = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_a = 16'h0, in_b = 16'h0;
    logic        in_ready;
    logic [15:0] add_a, add_b;
    logic [15:0] add_sum = 16'h0;
    logic        add_ready = 1'b0;
    logic        out_valid;
    logic [15:0] out_sum;
    logic        out_ready = 1'b0;
    logic        busy, sync_err;

    bfloat16_add_sequencer #(.IN_DEPTH(4), .OUT_DEPTH(2)) dut (
        .clock(clock), .nreset(nreset), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .in_ready(in_ready), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .add_ready(add_ready), .out_valid(out_valid), .out_sum(out_sum),
        .out_ready(out_ready), .busy(busy), .sync_err(sync_err)
    );

    always #5 clock = ~clock;

    int          checks = 0, errors = 0, cyc = 0;
    int          m_cnt = 0, drop_cyc = -1;
    bit          drop_req = 1'b0, saw_full = 1'b0;
    logic [15:0] m_a = 16'h0, m_b = 16'h0, m_sum = 16'h0;
    logic [15:0] prev_a = 16'h0, prev_b = 16'h0;
    logic        prev_rdy = 1'b0, prev_nrst = 1'b0;
    logic [15:0] rq[$];
    int          rc[$];
    int          base;
    logic [15:0] exp_burst [6] = '{16'h4000, 16'h4040, 16'h4080, 16'h40A0, 16'h40C0, 16'h40E0};

    function automatic real bf2r(input logic [15:0] x);
        logic [10:0] e;
        if (x[14:0] == 15'h0) return 0.0;
        e = {3'b000, x[14:7]} + 11'd896;
        return $bitstoreal({x[15], e, x[6:0], 45'h0});
    endfunction

    function automatic logic [15:0] r2bf(input real r);
        logic [63:0] b;
        logic [10:0] e;
        if (r == 0.0) return 16'h0000;
        b = $realtobits(r);
        e = b[62:52] - 11'd896;
        return {b[63], e[7:0], b[51:45]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model adder, operand-stability monitor and result collector, all at negedge.
    always @(negedge clock) begin
        if (nreset && prev_nrst && (add_a !== prev_a || add_b !== prev_b))
            chk("add_stable", 32'(prev_rdy), 32'd1);
        prev_a = add_a; prev_b = add_b; prev_nrst = nreset;
        if (out_valid && out_ready) begin
            rq.push_back(out_sum);
            rc.push_back(cyc);
        end
        case (m_cnt)
            0: begin
                if (drop_req) begin add_ready = 1'b0; drop_req = 1'b0; drop_cyc = cyc; end
                else add_ready = 1'b1;
                add_sum = m_sum;
            end
            1: begin add_ready = 1'b0; add_sum = 16'hDEAD; m_a = add_a; end
            default: begin
                add_ready = 1'b0; m_b = add_b;
                m_sum = r2bf(bf2r(m_a) + bf2r(m_b));
            end
        endcase
        prev_rdy = add_ready;
        m_cnt = (m_cnt == 2) ? 0 : m_cnt + 1;
        cyc++;
    end

    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b);
        int k = 0;
        in_valid = 1'b1; in_a = a; in_b = b;
        while (!in_ready && k < 200) begin saw_full = 1'b1; step(); k++; end
        chk("push_accept", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_res(input int n);
        int k = 0;
        while (rq.size() < n && k < 200) begin step(); k++; end
        chk("wait_results", 32'(rq.size() >= n), 32'd1);
    endtask

    initial begin
        #1 nreset = 1'b0;
        #1;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum",   32'(out_sum),   32'h0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_sync_err",  32'(sync_err),  32'd0);
        chk("rst_add_a",     32'(add_a),     32'h0);
        chk("rst_add_b",     32'(add_b),     32'h0);
        repeat (3) step();
        nreset = 1'b1;
        repeat (2) step();

        // single jobs
        out_ready = 1'b1;
        base = rq.size();
        push(16'h3F80, 16'h3F80);
        wait_res(base + 1);
        chk("single_1p1", 32'(rq[base]), 32'h4000);
        push(16'h4000, 16'h0000);
        wait_res(base + 2);
        chk("single_2p0", 32'(rq[base+1]), 32'h4000);

        // burst of six with free-flowing output
        repeat (4) step();
        saw_full = 1'b0;
        base = rq.size();
        push(16'h3F80, 16'h3F80);
        push(16'h4000, 16'h3F80);
        push(16'h4040, 16'h3F80);
        push(16'h4080, 16'h3F80);
        push(16'h40A0, 16'h3F80);
        push(16'h40C0, 16'h3F80);
        wait_res(base + 6);
        for (int k = 0; k < 6; k++) begin
            chk("burst_val", 32'(rq[base+k]), 32'(exp_burst[k]));
            if (k > 0) chk("burst_spacing", 32'(rc[base+k] - rc[base+k-1]), 32'd3);
        end
        chk("burst_in_full", 32'(saw_full), 32'd1);

        // backpressure: only OUT_DEPTH results may be issued
        repeat (5) step();
        out_ready = 1'b0;
        base = rq.size();
        push(16'h3F80, 16'h3F80);
        push(16'h4000, 16'h3F80);
        push(16'h4040, 16'h3F80);
        push(16'h4080, 16'h3F80);
        push(16'h40A0, 16'h3F80);
        repeat (20) step();
        chk("bp_none_out",  32'(rq.size() - base), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_head",      32'(out_sum),   32'h4000);
        chk("bp_last_iss",  32'(add_a),     32'h4000);
        chk("bp_busy",      32'(busy),      32'd1);
        out_ready = 1'b1;
        wait_res(base + 5);
        for (int k = 0; k < 5; k++) chk("bp_val", 32'(rq[base+k]), 32'(exp_burst[k]));
        chk("bp_drain_b2b", 32'(rc[base+1] - rc[base]), 32'd1);

        // adder skips one ready pulse
        repeat (6) step();
        chk("pre_err", 32'(sync_err), 32'd0);
        drop_req = 1'b1;
        begin
            int k = 0;
            while (!sync_err && k < 30) begin step(); k++; end
        end
        chk("err_seen",  32'(sync_err), 32'd1);
        chk("err_cycle", 32'(cyc), 32'(drop_cyc + 1));
        base = rq.size();
        push(16'h3F80, 16'h4000);
        push(16'h4080, 16'h4000);
        wait_res(base + 2);
        chk("resync_v0", 32'(rq[base]),   32'h4040);
        chk("resync_v1", 32'(rq[base+1]), 32'h40C0);
        chk("err_sticky", 32'(sync_err), 32'd1);

        // reset mid-round with jobs queued
        repeat (4) step();
        base = rq.size();
        push(16'h3F80, 16'h3F80);
        push(16'h4000, 16'h4000);
        push(16'h4040, 16'h4040);
        nreset = 1'b0;
        #1;
        chk("mr_in_ready",  32'(in_ready),  32'd1);
        chk("mr_out_valid", 32'(out_valid), 32'd0);
        chk("mr_out_sum",   32'(out_sum),   32'h0);
        chk("mr_busy",      32'(busy),      32'd0);
        chk("mr_sync_err",  32'(sync_err),  32'd0);
        chk("mr_add_a",     32'(add_a),     32'h0);
        chk("mr_add_b",     32'(add_b),     32'h0);
        repeat (3) step();
        nreset = 1'b1;
        repeat (30) step();
        chk("mr_no_stray", 32'(rq.size() - base), 32'd0);
        chk("mr_idle_ov",  32'(out_valid), 32'd0);
        chk("mr_idle_bsy", 32'(busy),      32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bfloat16_add_sequencer.md
BFLOAT16_ADD_SEQUENCER -- requirements
Module: bfloat16_add_sequencer

Interface
REQ-001 SHALL have parameter IN_DEPTH, default 4, input operand FIFO depth (power of two, >=2).
REQ-002 SHALL have parameter OUT_DEPTH, default 2, result FIFO depth (power of two, >=2).
REQ-003 clock  input  1  single clock; all state on its rising edge.
REQ-004 nreset  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  operand pair offered.
REQ-006 in_a  input  16  bfloat16 operand A.
REQ-007 in_b  input  16  bfloat16 operand B.
REQ-008 in_ready  output  1  operand FIFO not full.
REQ-009 add_a  output  16  to adder port a.
REQ-010 add_b  output  16  to adder port b.
REQ-011 add_sum  input  16  from adder sum.
REQ-012 add_ready  input  1  from adder ready; high once per 3-cycle adder round.
REQ-013 out_valid  output  1  result FIFO not empty.
REQ-014 out_sum  output  16  result FIFO head.
REQ-015 out_ready  input  1  consumer accepts head.
REQ-016 busy  output  1  job in flight or either FIFO non-empty.
REQ-017 sync_err  output  1  sticky adder-phase error.

Function
REQ-018 Adder contract: add_ready high in cycle R; adder samples a at end of R+1, b at end of R+2; add_sum valid for that pair in R+3 (add_ready high again).
REQ-019 Input push on in_valid & in_ready; pairs leave the FIFO in push order; push when full SHALL not occur (in_ready low).
REQ-020 FSM states: SYNC, RUN. Reset enters SYNC; SYNC->RUN on first cycle with add_ready=1.
REQ-021 phase counter 0..2: set to 0 on every add_ready=1 cycle, otherwise increments.
REQ-022 In RUN, add_ready=1 with phase!=2, or phase==2 with add_ready=0, SHALL set sync_err, clear inflight, return to SYNC; FIFO contents kept.
REQ-023 Round boundary = cycle with add_ready=1 in RUN or the SYNC->RUN transition cycle.
REQ-024 At round boundary, if inflight=1, add_sum SHALL be pushed to result FIFO that edge.
REQ-025 At same boundary, head pair SHALL be popped into add_a/add_b and inflight set to 1 iff input FIFO non-empty and result FIFO occupancy after this edge's capture and pop is < OUT_DEPTH; else inflight cleared, add_a/add_b hold.
REQ-026 add_a/add_b SHALL change only at round boundaries (stable through R+1..R+3).
REQ-027 Pop on out_valid & out_ready; simultaneous capture and pop at full SHALL keep occupancy unchanged, no loss.
REQ-028 Simultaneous input push and pop at full/empty SHALL be handled without loss or duplication.
REQ-029 Result order SHALL equal input order; no result dropped or duplicated while sync_err=0.
REQ-030 Throughput: one pair per adder round (3 cycles) when neither FIFO blocks.
REQ-031 Minimum latency: push in boundary cycle minus 1 -> out_valid 4 cycles after push edge.
REQ-032 Pointers SHALL wrap modulo depth; occupancy counts width log2(depth)+1.

Reset
REQ-033 nreset low SHALL immediately force: state SYNC, phase 0, inflight 0, FIFOs empty, add_a=add_b=16'h0000, in_ready=1, out_valid=0, out_sum=0, busy=0, sync_err=0.
REQ-034 Reset mid-round SHALL discard in-flight job and all buffered data; no result emitted for it.
REQ-035 sync_err SHALL clear only by reset.

Verification
REQ-036 Single job, real adder: in_a=3F80,in_b=3F80 -> one out_sum=4000; in_a=4000,in_b=0000 -> 4000.
REQ-037 Burst 6 pairs, out_ready=1: results in order, spacing exactly 3 cycles, in_ready low while 4 queued.
REQ-038 Backpressure: out_ready=0 for 20 cycles with 5 pairs -> exactly 2 results held, no issue past credit, all 5 delivered in order after release.
REQ-039 Stability: assert add_a/add_b never change except in add_ready=1 cycles; a sampled end of R+1 equals issued pair.
REQ-040 Phase error: model adder drops add_ready once -> sync_err=1 next cycle, resync on next add_ready, later pairs complete.
REQ-041 Reset mid-round with 3 queued -> outputs at reset values, no stray out_valid after release.
